cu_fsm: RTL and testbench
=========================

// Module: cu_fsm
// PURPOSE
//  Registered multicycle control FSM for the RV32I/RV64I core. It holds the state register
//  and latches the opcode in DECODE, and it computes the next state for all 16 legacy states.
//  It adds a memory ready/wait handshake, a memory timeout watchdog, an illegal-opcode TRAP
//  state and a retired-instruction counter. It sits between the instruction register and the
//  control-signal decoder, which consumes the `state` output.
// PARAMETERS
//  STATE_W      5   state register width; must be >= 5 (states 0..16 used)
//  MEM_TIMEOUT  15  max consecutive un-ready cycles in a memory state before TRAP (>=1)
//  CNT_W        32  width of retired-instruction counter
//  EN_TRAP      1   1: bad opcode/timeout -> TRAP(16); 0: bad opcode -> FETCH(0), timeout disabled
// PORTS
//  clk         in   1        rising-edge clock
//  reset       in   1        asynchronous, active-high reset
//  op          in   7        opcode from instruction register; sampled only in DECODE
//  mem_ready   in   1        memory completes access this cycle
//  stall       in   1        hold FSM (state, op_q, counters frozen)
//  trap_clr    in   1        leave TRAP to FETCH; ignored outside TRAP
//  state       out  STATE_W  current state (registered)
//  mem_req     out  1        1 when state is 0, 3 or 5 (decoded from registered state)
//  trap        out  1        1 when state == 16
//  timeout     out  1        sticky: TRAP was entered via watchdog; cleared by trap_clr/reset
//  retired     out  CNT_W    count of completed instructions, wraps modulo 2^CNT_W
// BEHAVIOUR
//  Reset (async): state=0, op_q=0, wait_cnt=0, timeout=0, retired=0.
//  States: 0 FETCH, 1 DECODE, 2 MEMADR, 3 MEMRD, 4 MEMWB, 5 MEMWR, 6 EXEC_R, 7 ALUWB,
//   8 BRANCH, 9 JUMP, 10 JAL, 11 AUIPC, 12 JALR, 13 EXEC_I, 14 BR2, 15 LUI, 16 TRAP.
//  Priority per edge: reset > stall > watchdog > normal transition.
//  Transitions (op_q = op latched on the 1->x edge):
//   0->1 when mem_ready, else hold.
//   1-> by op: 0000011/0100011 ->2; 011x011 ->6; 001x011 ->13; 1100011 ->8;
//       1101111/1100111 ->9; 0010111 ->11; 0110111 ->15; other -> 16 (or 0 if EN_TRAP=0).
//   2->3 if op_q=0000011, 2->5 if op_q=0100011.
//   3->4 on mem_ready, else hold.   5->0 on mem_ready, else hold.
//   4->0, 6->7, 7->0, 8->14, 14->0, 10->0, 12->0, 11->7, 13->7, 15->7.
//   9->10 if op_q=1101111, 9->12 if op_q=1100111.
//   16->0 on trap_clr, else hold.
//   Undefined encodings 17..2^STATE_W-1 -> 16 (or 0 if EN_TRAP=0).
//  Watchdog:
//   - wait_cnt clears on entering 0/3/5 and whenever mem_ready=1.
//   - It increments each unstalled cycle in 0/3/5 with mem_ready=0.
//   - If wait_cnt==MEM_TIMEOUT and mem_ready=0 (EN_TRAP=1): next state 16, timeout<=1.
//   - wait_cnt width = $clog2(MEM_TIMEOUT+1).
//  retired:
//   - +1 on each unstalled edge leaving 4, 7, 10, 12 or 14, or leaving 5 with mem_ready=1.
//   - Not incremented on TRAP entry or trap_clr.
//  mem_ready and stall in the same cycle: stall wins, and the access is treated as not completed.
//  Latency: the next state is visible one clock after the deciding inputs.
//  No combinational path from inputs to any output.
// STRUCTURE
//  cu_pkg: state localparams (S_FETCH..S_TRAP) and opcode constants (OP_LOAD, OP_STORE,
//   OP_R, OP_I, OP_BRANCH, OP_JAL, OP_JALR, OP_AUIPC, OP_LUI, with x-bit masks for 011x011/001x011).
//  Sub-module ns_logic: purely combinational next state from (state, op, op_q, mem_ready,
//   trap_clr, wd_fire). cu_fsm itself holds the registers, the watchdog and the counter.
// TESTING
//  1. Reset, then mem_ready=1, op=0000011: expect state sequence 0,1,2,3,4,0; retired=1.
//  2. Store with mem_ready=0 for 3 cycles in state 5: state holds 5 for 3 cycles, then 0;
//     mem_req=1 throughout; timeout=0.
//  3. Fetch with mem_ready stuck 0, MEM_TIMEOUT=15: state=16 after 16 cycles in 0; trap=1,
//     timeout=1; trap_clr=1 -> state 0, timeout=0.
//  4. op=1111111 in DECODE: state 16; retired unchanged; repeat with EN_TRAP=0 -> state 0.
//  5. op=1100111 in DECODE, change op to 1101111 in state 9: next state is 12 (op_q used).
//  6. stall=1 while in state 6, with mem_ready toggling: state, retired and wait_cnt frozen.
//     Assert reset in state 3: state=0 immediately, without waiting for clk.

Source files
------------

// File: rtl/cu_pkg.sv
`default_nettype none
// ------------------------------------------------------------------
// cu_pkg : state encodings and RV32I/RV64I opcode constants for cu_fsm
// Revision: 1.0
// ------------------------------------------------------------------
package cu_pkg;

  typedef enum logic [4:0] {
    S_FETCH  = 5'd0,
    S_DECODE = 5'd1,
    S_MEMADR = 5'd2,
    S_MEMRD  = 5'd3,
    S_MEMWB  = 5'd4,
    S_MEMWR  = 5'd5,
    S_EXEC_R = 5'd6,
    S_ALUWB  = 5'd7,
    S_BRANCH = 5'd8,
    S_JUMP   = 5'd9,
    S_JAL    = 5'd10,
    S_AUIPC  = 5'd11,
    S_JALR   = 5'd12,
    S_EXEC_I = 5'd13,
    S_BR2    = 5'd14,
    S_LUI    = 5'd15,
    S_TRAP   = 5'd16
  } state_e;

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [6:0] OP_STORE   = 7'b0100011;
  localparam logic [6:0] OP_R       = 7'b0110011;
  localparam logic [6:0] OP_I       = 7'b0010011;
  localparam logic [6:0] OP_BRANCH  = 7'b1100011;
  localparam logic [6:0] OP_JAL     = 7'b1101111;
  localparam logic [6:0] OP_JALR    = 7'b1100111;
  localparam logic [6:0] OP_AUIPC   = 7'b0010111;
  localparam logic [6:0] OP_LUI     = 7'b0110111;
  // Bit 3 is don't-care so the RV64 *W variants share the R/I paths.
  localparam logic [6:0] OP_RI_MASK = 7'b1110111;

  function automatic logic op_match(input logic [6:0] op,
                                    input logic [6:0] pat,
                                    input logic [6:0] mask);
    return (op & mask) == pat;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cu_fsm_ns_logic.sv
`default_nettype none
// ------------------------------------------------------------------
// ns_logic : combinational next-state function of the control FSM
// Revision: 1.0
// ------------------------------------------------------------------
module ns_logic
  import cu_pkg::*;
#(
  parameter int STATE_W = 5,
  parameter bit EN_TRAP = 1'b1
) (
  input  logic [STATE_W-1:0] state,
  input  logic [6:0]         op,
  input  logic [6:0]         op_q,
  input  logic               mem_ready,
  input  logic               trap_clr,
  input  logic               wd_fire,
  output logic [STATE_W-1:0] next_state
);

  function automatic logic [STATE_W-1:0] sw(input state_e s);
    return STATE_W'(s);
  endfunction

  localparam logic [STATE_W-1:0] c_bad = EN_TRAP ? STATE_W'(S_TRAP) : STATE_W'(S_FETCH);

  logic [STATE_W-1:0] w_ns;

  always_comb begin
    w_ns = state;
    case (state[4:0])
      S_FETCH:  w_ns = mem_ready ? sw(S_DECODE) : sw(S_FETCH);
      S_DECODE: begin
        if (op == OP_LOAD || op == OP_STORE)         w_ns = sw(S_MEMADR);
        else if (op_match(op, OP_R, OP_RI_MASK))     w_ns = sw(S_EXEC_R);
        else if (op_match(op, OP_I, OP_RI_MASK))     w_ns = sw(S_EXEC_I);
        else if (op == OP_BRANCH)                    w_ns = sw(S_BRANCH);
        else if (op == OP_JAL || op == OP_JALR)      w_ns = sw(S_JUMP);
        else if (op == OP_AUIPC)                     w_ns = sw(S_AUIPC);
        else if (op == OP_LUI)                       w_ns = sw(S_LUI);
        else                                         w_ns = c_bad;
      end
      S_MEMADR: begin
        if (op_q == OP_LOAD)       w_ns = sw(S_MEMRD);
        else if (op_q == OP_STORE) w_ns = sw(S_MEMWR);
        else                       w_ns = c_bad;
      end
      S_MEMRD:  w_ns = mem_ready ? sw(S_MEMWB) : sw(S_MEMRD);
      S_MEMWB:  w_ns = sw(S_FETCH);
      S_MEMWR:  w_ns = mem_ready ? sw(S_FETCH) : sw(S_MEMWR);
      S_EXEC_R: w_ns = sw(S_ALUWB);
      S_ALUWB:  w_ns = sw(S_FETCH);
      S_BRANCH: w_ns = sw(S_BR2);
      S_BR2:    w_ns = sw(S_FETCH);
      S_JUMP: begin
        if (op_q == OP_JAL)       w_ns = sw(S_JAL);
        else if (op_q == OP_JALR) w_ns = sw(S_JALR);
        else                      w_ns = c_bad;
      end
      S_JAL:    w_ns = sw(S_FETCH);
      S_JALR:   w_ns = sw(S_FETCH);
      S_AUIPC:  w_ns = sw(S_ALUWB);
      S_EXEC_I: w_ns = sw(S_ALUWB);
      S_LUI:    w_ns = sw(S_ALUWB);
      S_TRAP:   w_ns = trap_clr ? sw(S_FETCH) : sw(S_TRAP);
      default:  w_ns = c_bad;
    endcase
    // Encodings above TRAP, including any upper bits of a wide register.
    if (state > sw(S_TRAP)) w_ns = c_bad;
    if (wd_fire)            w_ns = sw(S_TRAP);
  end

  assign next_state = w_ns;

endmodule
`default_nettype wire

// File: rtl/cu_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// cu_fsm : multicycle control FSM with memory watchdog, trap state and
//          retired-instruction counter
// Revision: 1.0
// ------------------------------------------------------------------
module cu_fsm
  import cu_pkg::*;
#(
  parameter int STATE_W     = 5,
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32,
  parameter bit EN_TRAP     = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [6:0]         op,
  input  logic               mem_ready,
  input  logic               stall,
  input  logic               trap_clr,
  output logic [STATE_W-1:0] state,
  output logic               mem_req,
  output logic               trap,
  output logic               timeout,
  output logic [CNT_W-1:0]   retired
);

  localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WC_W-1:0] c_wc_max = WC_W'(MEM_TIMEOUT);

  function automatic logic is_mem(input logic [STATE_W-1:0] s);
    return s == STATE_W'(S_FETCH) || s == STATE_W'(S_MEMRD) || s == STATE_W'(S_MEMWR);
  endfunction

  function automatic logic is_st(input logic [STATE_W-1:0] s, input state_e e);
    return s == STATE_W'(e);
  endfunction

  logic [STATE_W-1:0] r_state;
  logic [6:0]         r_op_q;
  logic [WC_W-1:0]    r_wait_cnt;
  logic               r_timeout;
  logic [CNT_W-1:0]   r_retired;

  logic [STATE_W-1:0] w_next;
  logic               w_in_mem;
  logic               w_wd_fire;
  logic               w_enter_mem;
  logic               w_retire;

  assign w_in_mem    = is_mem(r_state);
  assign w_wd_fire   = EN_TRAP && w_in_mem && !mem_ready && (r_wait_cnt == c_wc_max);
  assign w_enter_mem = is_mem(w_next) && (w_next != r_state);
  assign w_retire    = is_st(r_state, S_MEMWB) || is_st(r_state, S_ALUWB) ||
                       is_st(r_state, S_JAL)   || is_st(r_state, S_JALR)  ||
                       is_st(r_state, S_BR2)   || (is_st(r_state, S_MEMWR) && mem_ready);

  ns_logic #(
    .STATE_W (STATE_W),
    .EN_TRAP (EN_TRAP)
  ) u_ns (
    .state      (r_state),
    .op         (op),
    .op_q       (r_op_q),
    .mem_ready  (mem_ready),
    .trap_clr   (trap_clr),
    .wd_fire    (w_wd_fire),
    .next_state (w_next)
  );

  // Stall freezes every register; a mem_ready seen under stall is ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= '0;
      r_op_q     <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
      r_retired  <= '0;
    end else if (!stall) begin
      r_state <= w_next;
      if (is_st(r_state, S_DECODE)) r_op_q <= op;

      if (w_wd_fire || mem_ready || w_enter_mem) r_wait_cnt <= '0;
      else if (w_in_mem) begin
        if (r_wait_cnt != c_wc_max) r_wait_cnt <= r_wait_cnt + WC_W'(1);
      end else r_wait_cnt <= '0;

      if (w_wd_fire) r_timeout <= 1'b1;
      else if (is_st(r_state, S_TRAP) && trap_clr) r_timeout <= 1'b0;

      if (w_retire) r_retired <= r_retired + CNT_W'(1);
    end
  end

  assign state   = r_state;
  assign mem_req = w_in_mem;
  assign trap    = is_st(r_state, S_TRAP);
  assign timeout = r_timeout;
  assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_cu_fsm.sv
`default_nettype none
// ------------------------------------------------------------------
// tb_cu_fsm : directed self-checking bench for cu_fsm (trap on and off)
// Revision: 1.0
// ------------------------------------------------------------------
module tb_cu_fsm;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  op;
  logic        mem_ready;
  logic        stall;
  logic        trap_clr;

  logic [4:0]  state,   state1;
  logic        mem_req, mem_req1;
  logic        trap,    trap1;
  logic        timeout, timeout1;
  logic [31:0] retired, retired1;

  int total = 0;
  int bad   = 0;
  logic [4:0] exp_q[$];

  always #5 clk = ~clk;

  cu_fsm #(.STATE_W(5), .MEM_TIMEOUT(15), .CNT_W(32), .EN_TRAP(1'b1)) dut (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .stall(stall),
    .trap_clr(trap_clr), .state(state), .mem_req(mem_req), .trap(trap),
    .timeout(timeout), .retired(retired)
  );

  cu_fsm #(.STATE_W(5), .MEM_TIMEOUT(15), .CNT_W(32), .EN_TRAP(1'b0)) dut_nt (
    .clk(clk), .reset(reset), .op(op), .mem_ready(mem_ready), .stall(stall),
    .trap_clr(trap_clr), .state(state1), .mem_req(mem_req1), .trap(trap1),
    .timeout(timeout1), .retired(retired1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Expected next state is queued with the stimulus, then popped once the edge has happened.
  task automatic step(input logic [4:0] exp_st, input string tag);
    logic [4:0] e;
    exp_q.push_back(exp_st);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk(tag, 64'(state), 64'(e));
  endtask

  initial begin
    #200000;
    $display("FAIL run_limit observed=expired expected=finish");
    $fatal(1, "run limit");
  end

  initial begin
    reset = 1'b1; op = 7'd0; mem_ready = 1'b0; stall = 1'b0; trap_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state",   64'(state),   64'd0);
    chk("rst_retired", 64'(retired), 64'd0);
    chk("rst_timeout", 64'(timeout), 64'd0);
    chk("rst_trap",    64'(trap),    64'd0);
    chk("rst_memreq",  64'(mem_req), 64'd1);
    reset = 1'b0;

    // Load
    mem_ready = 1'b1; op = 7'b0000011;
    step(5'd1, "ld_decode");
    step(5'd2, "ld_memadr");
    step(5'd3, "ld_memrd");
    step(5'd4, "ld_memwb");
    step(5'd0, "ld_fetch");
    chk("ld_retired", 64'(retired), 64'd1);

    // Store with three wait cycles
    op = 7'b0100011;
    step(5'd1, "st_decode");
    step(5'd2, "st_memadr");
    step(5'd5, "st_memwr");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(5'd5, "st_wait");
      chk("st_memreq", 64'(mem_req), 64'd1);
    end
    mem_ready = 1'b1;
    step(5'd0, "st_done");
    chk("st_retired", 64'(retired), 64'd2);
    chk("st_timeout", 64'(timeout), 64'd0);

    // Fetch watchdog
    mem_ready = 1'b0;
    for (int i = 0; i < 15; i++) step(5'd0, "wd_hold");
    step(5'd16, "wd_trap");
    chk("wd_trapout",  64'(trap),     64'd1);
    chk("wd_timeout",  64'(timeout),  64'd1);
    chk("wd_memreq",   64'(mem_req),  64'd0);
    chk("nt_wd_state", 64'(state1),   64'd0);
    chk("nt_timeout",  64'(timeout1), 64'd0);
    step(5'd16, "trap_hold");
    trap_clr = 1'b1;
    step(5'd0, "trap_clr");
    chk("clr_timeout", 64'(timeout), 64'd0);
    chk("clr_trap",    64'(trap),    64'd0);
    chk("clr_retired", 64'(retired), 64'd2);
    trap_clr = 1'b0;

    // Illegal opcode
    op = 7'b1111111; mem_ready = 1'b1;
    step(5'd1, "bad_decode");
    step(5'd16, "bad_trap");
    chk("bad_timeout", 64'(timeout), 64'd0);
    chk("bad_retired", 64'(retired), 64'd2);
    chk("nt_bad_state", 64'(state1), 64'd0);
    mem_ready = 1'b0; trap_clr = 1'b1;
    step(5'd0, "bad_clr");
    trap_clr = 1'b0;

    // JALR latched, opcode changed afterwards
    op = 7'b1100111; mem_ready = 1'b1;
    step(5'd1, "jr_decode");
    step(5'd9, "jr_jump");
    op = 7'b1101111;
    step(5'd12, "jr_opq");
    step(5'd0, "jr_fetch");
    chk("jr_retired", 64'(retired), 64'd3);

    // Stall in EXEC_R
    op = 7'b0110011;
    step(5'd1, "r_decode");
    step(5'd6, "r_exec");
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      mem_ready = i[0];
      step(5'd6, "stall_hold");
      chk("stall_retired", 64'(retired), 64'd3);
    end
    stall = 1'b0; mem_ready = 1'b1;
    step(5'd7, "r_aluwb");
    step(5'd0, "r_fetch");
    chk("r_retired", 64'(retired), 64'd4);

    // Watchdog count frozen across a stall
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) step(5'd0, "wdf_pre");
    stall = 1'b1;
    for (int i = 0; i < 6; i++) begin
      mem_ready = i[0];
      step(5'd0, "wdf_stall");
    end
    stall = 1'b0; mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) step(5'd0, "wdf_post");
    step(5'd16, "wdf_trap");
    chk("wdf_timeout", 64'(timeout), 64'd1);
    trap_clr = 1'b1;
    step(5'd0, "wdf_clr");
    trap_clr = 1'b0;
    chk("wdf_retired", 64'(retired), 64'd4);

    // Asynchronous reset while in MEMRD
    op = 7'b0000011; mem_ready = 1'b1;
    step(5'd1, "ar_decode");
    step(5'd2, "ar_memadr");
    step(5'd3, "ar_memrd");
    mem_ready = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async_rst_state",   64'(state),   64'd0);
    chk("async_rst_retired", 64'(retired), 64'd0);
    reset = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
